jtframe_z80_shram_arb: RTL and testbench
========================================

// Module: jtframe_z80_shram_arb
// PURPOSE
//  Arbiter sharing one single-port synchronous 8-bit RAM (shared/comm RAM) between the
//  sound Z80 and the main CPU. Sits beside the Z80 subsystem.
//  z80_busy feeds the dev_busy input of the Z80 wait/cen-gating logic.
//  main_ok is the main-CPU acknowledge (DTACK source).
//  Fixed 3-clock access slot; round-robin on conflict.
// PARAMETERS
//  AW       11   shared RAM address width
// PORTS
//  rst_n      in   1    async reset, active-low
//  clk        in   1    system clock
//  z80_cs     in   1    Z80 request; held until its access is done
//  z80_we     in   1    1=write, 0=read; sampled with z80_cs
//  z80_addr   in   AW   Z80 address
//  z80_dout   in   8    Z80 write data
//  z80_din    out  8    read data returned to Z80
//  z80_busy   out  1    1 while the Z80 request is pending/unserved (combinational)
//  main_cs    in   1    main CPU request; held until main_ok
//  main_we    in   1    1=write
//  main_addr  in   AW   main CPU address
//  main_dout  in   8    main CPU write data
//  main_din   out  8    read data returned to main CPU
//  main_ok    out  1    access done; stays high until main_cs falls
//  ram_addr   out  AW   RAM address (registered)
//  ram_din    out  8    RAM write data (registered)
//  ram_we     out  1    RAM write strobe (registered, one clk)
//  ram_dout   in   8    RAM read data, 1-clk synchronous latency
// BEHAVIOUR
//  Reset: all outputs 0, except z80_busy, which equals z80_cs.
//    FSM=IDLE; served flags=0; last_gnt=MAIN, so the Z80 wins the first tie.
//  Per port: pending = cs & ~served.
//    served is set at the DONE edge of that port's access.
//    served clears on the first clk with cs low.
//    One access per cs assertion.
//  z80_busy = z80_cs & ~z80_served.
//  main_ok = main_served & main_cs.
//  FSM: IDLE -> ACC -> DONE -> IDLE.
//    IDLE (edge E0): choose a pending port.
//      If both are pending, grant the port that is not last_gnt; update last_gnt.
//      Register ram_addr/ram_din; ram_we = granted we.
//    ACC: RAM addr/we stable; RAM samples at edge E1; ram_we returns to 0 at E1.
//    DONE (edge E2): on a read, capture ram_dout into the granted port's *_din.
//      Set its served flag; go to IDLE.
//  Latency: cs sampled at E0 -> busy low / ok high after E2.
//    Max throughput is one access per 3 clks.
//    Worst-case wait under contention is 6 clks.
//  *_din holds its last read value; writes leave it unchanged.
//  If cs drops mid-slot, the slot still completes and the write is committed.
//    served is not set (cs low), so no stale ok/busy release follows.
//  A request arriving while FSM!=IDLE waits for the next IDLE.
//  The IDLE edge is never skipped: the idle-to-grant gap is one edge.
//  rst_n low mid-slot: immediate return to reset state.
//    ram_we drops asynchronously; the partial write is the RAM's concern.
//  Address/we/data must stay stable while cs is high. They are only sampled at E0.
// CONFIGURATION
//  JTFRAME_SHRAM_STATS_EN defined:
//    Adds output conflict_cnt[15:0]: +1 at each IDLE edge where both ports are pending.
//    Saturates at 16'hFFFF; reset 0.
//  JTFRAME_SHRAM_STATS_EN undefined:
//    Port and counter are absent; arbitration is identical.
// STRUCTURE
//  Package jtframe_shram_pkg:
//    state enum {IDLE,ACC,DONE}
//    grant constants GNT_Z80=1'b0, GNT_MAIN=1'b1
//  Sub-module jtframe_shram_port, instantiated twice:
//    served/pending tracker plus registered read-data return.
//  Top level: FSM, round-robin, RAM mux.
// TESTING
//  1. Z80 read alone, RAM[0x010]=0x5A:
//     z80_cs at E0 -> z80_busy low after E2, z80_din=0x5A.
//  2. Main write 0xC3 @0x100, then Z80 read @0x100:
//     ram_we one clk in ACC; z80_din=0xC3.
//  3. Both cs rise together after reset:
//     Z80 slot first (ram_addr=z80_addr), main slot next; main_ok after 6 clks.
//  4. Both held continuously, re-asserted after each ack (x4):
//     grants alternate Z,M,Z,M; no port waits more than 6 clks.
//  5. main_cs drops during ACC of a write:
//     write committed; main_ok never rises; a new main_cs gets a fresh slot.
//  6. rst_n pulse during ACC:
//     ram_we=0 at once, outputs 0; FSM idle; the next Z80 request is served normally.

Source files
------------

// File: rtl/jtframe_shram_pkg.sv
// Shared constants for the Z80 / main-CPU shared-RAM arbiter.
// FSM state codes, grant identifiers and the round-robin pick helper.
package jtframe_shram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic GNT_Z80  = 1'b0;
  localparam logic GNT_MAIN = 1'b1;

  // On a tie the port that did not win last time gets the slot.
  function automatic logic rr_pick(
    input logic z_pend,
    input logic m_pend,
    input logic last
  );
    if (z_pend && m_pend) return ~last;
    return m_pend ? GNT_MAIN : GNT_Z80;
  endfunction

endpackage

// File: rtl/jtframe_shram_port.sv
// Per-port served/pending tracker with registered read-data return.
// Ports: rst_n, clk, cs, done, rd, rdata in; pending, served, din out.
module jtframe_shram_port
  import jtframe_shram_pkg::*;
(
  input  logic       rst_n,
  input  logic       clk,
  input  logic       cs,
  input  logic       done,
  input  logic       rd,
  input  logic [7:0] rdata,
  output logic       pending,
  output logic       served,
  output logic [7:0] din
);

  logic       served_q, served_d;
  logic [7:0] din_q, din_d;

  // served only latches while cs is still up, so an
  // abandoned slot never releases busy/ok later.
  always_comb begin
    served_d = cs ? (served_q | done) : 1'b0;
    din_d    = (done & rd) ? rdata : din_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      served_q <= served_d;
      din_q    <= din_d;
    end
  end

  assign pending = cs & ~served_q;
  assign served  = served_q;
  assign din     = din_q;

endmodule

// File: rtl/jtframe_z80_shram_arb.sv
// Z80 / main-CPU arbiter for one synchronous 8-bit shared RAM, 3-clk slots.
// Ports: z80_* and main_* request sides, ram_* RAM side. Option:
// JTFRAME_SHRAM_STATS_EN adds conflict_cnt (saturating tie counter).
module jtframe_z80_shram_arb
  import jtframe_shram_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          z80_cs,
  input  logic          z80_we,
  input  logic [AW-1:0] z80_addr,
  input  logic [7:0]    z80_dout,
  output logic [7:0]    z80_din,
  output logic          z80_busy,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic [7:0]    main_din,
  output logic          main_ok,
`ifdef JTFRAME_SHRAM_STATS_EN
  output logic [15:0]   conflict_cnt,
`endif
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          we_q, we_d;

  logic z_pend, m_pend, z_srv, m_srv;
  logic z_done, m_done, sel;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = 1'b0;
    sel     = rr_pick(z_pend, m_pend, last_q);
    unique case (state_q)
      ST_IDLE: begin
        if (z_pend | m_pend) begin
          state_d = ST_ACC;
          gnt_d   = sel;
          last_d  = sel;
          wr_d    = sel ? main_we : z80_we;
          addr_d  = sel ? main_addr : z80_addr;
          wdat_d  = sel ? main_dout : z80_dout;
          we_d    = sel ? main_we : z80_we;
        end
      end
      ST_ACC:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_Z80;
      last_q  <= GNT_MAIN;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
    end
  end

  assign z_done = (state_q == ST_DONE) && (gnt_q == GNT_Z80);
  assign m_done = (state_q == ST_DONE) && (gnt_q == GNT_MAIN);

  jtframe_shram_port u_z80 (
    .rst_n   (rst_n),
    .clk     (clk),
    .cs      (z80_cs),
    .done    (z_done),
    .rd      (~wr_q),
    .rdata   (ram_dout),
    .pending (z_pend),
    .served  (z_srv),
    .din     (z80_din)
  );

  jtframe_shram_port u_main (
    .rst_n   (rst_n),
    .clk     (clk),
    .cs      (main_cs),
    .done    (m_done),
    .rd      (~wr_q),
    .rdata   (ram_dout),
    .pending (m_pend),
    .served  (m_srv),
    .din     (main_din)
  );

  assign z80_busy = z80_cs & ~z_srv;
  assign main_ok  = main_cs & m_srv;
  assign ram_addr = addr_q;
  assign ram_din  = wdat_q;
  assign ram_we   = we_q;

`ifdef JTFRAME_SHRAM_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && z_pend && m_pend && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_jtframe_z80_shram_arb.sv
// Random-traffic bench for the shared-RAM arbiter.
// Reference: slot-based transaction model with its own memory image.
module tb_jtframe_z80_shram_arb;

  logic        rst_n, clk;
  logic        cs_v [2];
  logic        we_v [2];
  logic [10:0] addr_v [2];
  logic [7:0]  dat_v [2];

  logic        z80_cs, z80_we, main_cs, main_we;
  logic [10:0] z80_addr, main_addr, ram_addr;
  logic [7:0]  z80_dout, main_dout, z80_din, main_din;
  logic [7:0]  ram_din, ram_dout;
  logic        z80_busy, main_ok, ram_we;

  assign z80_cs    = cs_v[0];
  assign z80_we    = we_v[0];
  assign z80_addr  = addr_v[0];
  assign z80_dout  = dat_v[0];
  assign main_cs   = cs_v[1];
  assign main_we   = we_v[1];
  assign main_addr = addr_v[1];
  assign main_dout = dat_v[1];

  jtframe_z80_shram_arb #(.AW(11)) dut (
    .rst_n     (rst_n),
    .clk       (clk),
    .z80_cs    (z80_cs),
    .z80_we    (z80_we),
    .z80_addr  (z80_addr),
    .z80_dout  (z80_dout),
    .z80_din   (z80_din),
    .z80_busy  (z80_busy),
    .main_cs   (main_cs),
    .main_we   (main_we),
    .main_addr (main_addr),
    .main_dout (main_dout),
    .main_din  (main_din),
    .main_ok   (main_ok),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  // Synchronous single-port RAM with a preload path for the bench.
  logic [7:0]  mem [0:2047];
  logic        ld_en;
  logic [10:0] ld_addr;
  logic [7:0]  ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a slot is (owner, we, addr, data) with a count of
  // edges left; memory writes land at the RAM sampling edge.
  logic [7:0]  refmem [0:2047];
  logic [10:0] atab [16];
  int          sl;
  logic        sp, swe, last;
  logic [10:0] sa;
  logic [7:0]  sd;
  logic        srv [2];
  logic [7:0]  edin [2];
  int          waitc [2];

  task automatic model_reset();
    sl = 0; sp = 1'b0; swe = 1'b0; last = 1'b1;
    sa = '0; sd = '0;
    for (int p = 0; p < 2; p++) begin
      srv[p] = 1'b0; edin[p] = 8'h00; waitc[p] = 0;
    end
  endtask

  task automatic model_edge();
    logic pend [2];
    logic done [2];
    for (int p = 0; p < 2; p++) begin
      pend[p] = cs_v[p] && !srv[p];
      done[p] = 1'b0;
    end
    if (sl == 2) begin
      if (swe) refmem[sa] = sd;
      sl = 1;
    end else if (sl == 1) begin
      if (!swe) edin[sp] = refmem[sa];
      done[sp] = 1'b1;
      sl = 0;
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) sp = !last;
      else sp = pend[1];
      last = sp;
      swe = we_v[sp]; sa = addr_v[sp]; sd = dat_v[sp];
      sl = 2;
    end
    for (int p = 0; p < 2; p++) begin
      waitc[p] = pend[p] ? waitc[p] + 1 : 0;
      if (done[p] && cs_v[p]) chk("wait_le_6", waitc[p] <= 6, 1);
      srv[p] = cs_v[p] ? (srv[p] || done[p]) : 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("z80_busy", z80_busy, cs_v[0] && !srv[0]);
    chk("main_ok", main_ok, cs_v[1] && srv[1]);
    chk("ram_we", ram_we, (sl == 2) && swe);
    chk("ram_addr", ram_addr, sa);
    chk("ram_din", ram_din, sd);
    chk("z80_din", z80_din, edin[0]);
    chk("main_din", main_din, edin[1]);
  endtask

  int next_rst;

  initial begin
    atab[0]  = 11'h000; atab[1]  = 11'h010; atab[2]  = 11'h100;
    atab[3]  = 11'h7FF; atab[4]  = 11'h001; atab[5]  = 11'h155;
    atab[6]  = 11'h2AA; atab[7]  = 11'h400; atab[8]  = 11'h3FF;
    atab[9]  = 11'h0F0; atab[10] = 11'h50A; atab[11] = 11'h123;
    atab[12] = 11'h6C6; atab[13] = 11'h080; atab[14] = 11'h7F0;
    atab[15] = 11'h222;
    rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int p = 0; p < 2; p++) begin
      cs_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; dat_v[p] = '0;
    end
    model_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = atab[i];
      ld_data = (i == 1) ? 8'h5A : 8'($urandom);
      refmem[atab[i]] = ld_data;
    end
    @(negedge clk);
    ld_en = 1'b0;
    cs_v[0] = 1'b1;
    #1;
    chk("rst_z80_busy", z80_busy, 1);
    chk("rst_main_ok", main_ok, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_z80_din", z80_din, 0);
    chk("rst_main_din", main_din, 0);
    // Both ports request together straight after reset: Z80 first.
    we_v[0] = 1'b0; addr_v[0] = 11'h010;
    cs_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 11'h100; dat_v[1] = 8'hC3;
    @(negedge clk);
    rst_n = 1'b1;
    next_rst = 300;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      if (cyc >= next_rst && sl == 2) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ram_we", ram_we, 0);
        check_outputs();
        #1;
        rst_n = 1'b1;
        next_rst = cyc + 350;
      end
      for (int p = 0; p < 2; p++) begin
        if (!cs_v[p]) begin
          if ($urandom_range(2) == 0) begin
            cs_v[p]   = 1'b1;
            we_v[p]   = 1'($urandom_range(1));
            addr_v[p] = atab[$urandom_range(15)];
            dat_v[p]  = 8'($urandom);
          end
        end else if (srv[p]) begin
          if ($urandom_range(1) == 0) cs_v[p] = 1'b0;
        end else if ($urandom_range(30) == 0) begin
          cs_v[p] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
